// File: rtl/can_rx_sequencer.sv
// Frame-level sequencer for the CAN receive path: tracks frame position from bit strobes,
// drives destuffer/CRC/capture controls, holds one accepted frame and counts errors/overruns.
module can_rx_sequencer #(
    parameter int unsigned IDLE_BITS = 11,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             baud_lock,
    input  logic             raw_stb,
    input  logic             dat_stb,
    input  logic             bit_in,
    input  logic             stuff_err,
    input  logic             crc_zero,
    input  logic             rd_ack,
    output logic             unstuff_en,
    output logic             crc_clr,
    output logic             cap_en,
    output logic             frame_valid,
    output logic             frame_ext,
    output logic             frame_rtr,
    output logic [3:0]       frame_dlc,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ovr_cnt,
    output logic             bus_idle
);
    localparam int unsigned IDLE_W     = $clog2(IDLE_BITS + 1);
    localparam int unsigned BIT_W      = 7;
    localparam int unsigned EOF_PRESET = 7;

    typedef enum logic [3:0] {
        ST_IDLE, ST_SOF_WAIT, ST_ARB, ST_EXT, ST_CTRL, ST_DATA,
        ST_CRC, ST_CRC_CHK, ST_DELIM, ST_ACK, ST_EOF
    } state_t;

    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BIT_W-1:0]  data_len_q, data_len_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              ext_q, ext_d, rtr_q, rtr_d;
    logic [3:0]        dlc_q, dlc_d, dlc_shift;
    logic [BIT_W-1:0]  dlc_first, dlc_last;
    logic              unstuff_en_d, cap_en_d, crc_clr_d, bus_idle_d;
    logic              frame_valid_d, frame_ext_d, frame_rtr_d;
    logic [3:0]        frame_dlc_d;
    logic [CNT_W-1:0]  err_cnt_d, ovr_cnt_d;
    logic              err_hit, commit;

    assign dlc_shift = {dlc_q[2:0], bit_in};
    // Control field is r0+DLC for base frames, r1+r0+DLC for extended frames
    assign dlc_first = ext_q ? BIT_W'(2) : BIT_W'(1);
    assign dlc_last  = ext_q ? BIT_W'(5) : BIT_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            data_len_q  <= '0;
            idle_cnt_q  <= '0;
            ext_q       <= 1'b0;
            rtr_q       <= 1'b0;
            dlc_q       <= '0;
            unstuff_en  <= 1'b0;
            cap_en      <= 1'b0;
            crc_clr     <= 1'b0;
            bus_idle    <= 1'b0;
            frame_valid <= 1'b0;
            frame_ext   <= 1'b0;
            frame_rtr   <= 1'b0;
            frame_dlc   <= '0;
            err_cnt     <= '0;
            ovr_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            data_len_q  <= data_len_d;
            idle_cnt_q  <= idle_cnt_d;
            ext_q       <= ext_d;
            rtr_q       <= rtr_d;
            dlc_q       <= dlc_d;
            unstuff_en  <= unstuff_en_d;
            cap_en      <= cap_en_d;
            crc_clr     <= crc_clr_d;
            bus_idle    <= bus_idle_d;
            frame_valid <= frame_valid_d;
            frame_ext   <= frame_ext_d;
            frame_rtr   <= frame_rtr_d;
            frame_dlc   <= frame_dlc_d;
            err_cnt     <= err_cnt_d;
            ovr_cnt     <= ovr_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        data_len_d    = data_len_q;
        idle_cnt_d    = idle_cnt_q;
        ext_d         = ext_q;
        rtr_d         = rtr_q;
        dlc_d         = dlc_q;
        unstuff_en_d  = unstuff_en;
        cap_en_d      = cap_en;
        crc_clr_d     = 1'b0;
        bus_idle_d    = bus_idle;
        frame_valid_d = frame_valid;
        frame_ext_d   = frame_ext;
        frame_rtr_d   = frame_rtr;
        frame_dlc_d   = frame_dlc;
        err_cnt_d     = err_cnt;
        ovr_cnt_d     = ovr_cnt;
        err_hit       = 1'b0;
        commit        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (raw_stb) begin
                    if (!bit_in) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q >= IDLE_W'(IDLE_BITS - 1)) begin
                        idle_cnt_d = '0;
                        bus_idle_d = 1'b1;
                        state_d    = ST_SOF_WAIT;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
            ST_SOF_WAIT: begin
                if (raw_stb && !bit_in) begin
                    crc_clr_d    = 1'b1;
                    unstuff_en_d = 1'b1;
                    cap_en_d     = 1'b1;
                    bus_idle_d   = 1'b0;
                    bit_cnt_d    = '0;
                    ext_d        = 1'b0;
                    rtr_d        = 1'b0;
                    dlc_d        = '0;
                    state_d      = ST_ARB;
                end
            end
            // Bit 11 is RTR for base frames (SRR otherwise), bit 12 is IDE
            ST_ARB: begin
                if (raw_stb && stuff_err) begin
                    err_hit = 1'b1;
                end else if (dat_stb) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(11)) rtr_d = bit_in;
                    if (bit_cnt_q == BIT_W'(12)) begin
                        bit_cnt_d = '0;
                        ext_d     = bit_in;
                        state_d   = bit_in ? ST_EXT : ST_CTRL;
                    end
                end
            end
            ST_EXT: begin
                if (raw_stb && stuff_err) begin
                    err_hit = 1'b1;
                end else if (dat_stb) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(18)) begin
                        rtr_d     = bit_in;
                        bit_cnt_d = '0;
                        state_d   = ST_CTRL;
                    end
                end
            end
            ST_CTRL: begin
                if (raw_stb && stuff_err) begin
                    err_hit = 1'b1;
                end else if (dat_stb) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q >= dlc_first) dlc_d = dlc_shift;
                    if (bit_cnt_q == dlc_last) begin
                        bit_cnt_d  = '0;
                        data_len_d = dlc_shift[3] ? BIT_W'(64) : BIT_W'({dlc_shift[2:0], 3'b000});
                        state_d    = (rtr_q || dlc_shift == 4'd0) ? ST_CRC : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (raw_stb && stuff_err) begin
                    err_hit = 1'b1;
                end else if (dat_stb) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == data_len_q - BIT_W'(1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (raw_stb && stuff_err) begin
                    err_hit = 1'b1;
                end else if (dat_stb) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(14)) begin
                        bit_cnt_d    = '0;
                        unstuff_en_d = 1'b0;
                        cap_en_d     = 1'b0;
                        state_d      = ST_CRC_CHK;
                    end
                end
            end
            ST_CRC_CHK: begin
                if (!crc_zero) err_hit = 1'b1;
                else           state_d = ST_DELIM;
            end
            ST_DELIM: begin
                if (raw_stb) begin
                    if (!bit_in) err_hit = 1'b1;
                    else         state_d = ST_ACK;
                end
            end
            // Slot bit is don't-care; only the ACK delimiter is checked
            ST_ACK: begin
                if (raw_stb) begin
                    if (bit_cnt_q == '0) begin
                        bit_cnt_d = BIT_W'(1);
                    end else if (!bit_in) begin
                        err_hit = 1'b1;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = ST_EOF;
                    end
                end
            end
            ST_EOF: begin
                if (raw_stb) begin
                    if (!bit_in) begin
                        err_hit = 1'b1;
                    end else if (bit_cnt_q == BIT_W'(6)) begin
                        commit     = 1'b1;
                        bit_cnt_d  = '0;
                        idle_cnt_d = IDLE_W'(EOF_PRESET);
                        state_d    = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Lost lock aborts silently; otherwise protocol errors abort and are counted
        if (!baud_lock) begin
            err_hit      = 1'b0;
            commit       = 1'b0;
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            idle_cnt_d   = '0;
            unstuff_en_d = 1'b0;
            cap_en_d     = 1'b0;
            bus_idle_d   = 1'b0;
        end else if (err_hit) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            idle_cnt_d   = '0;
            unstuff_en_d = 1'b0;
            cap_en_d     = 1'b0;
        end

        if (err_hit && err_cnt != '1) err_cnt_d = err_cnt + CNT_W'(1);

        // One-slot hold: an ack in the commit cycle frees the slot for the new frame
        if (commit) begin
            if (!frame_valid || rd_ack) begin
                frame_valid_d = 1'b1;
                frame_ext_d   = ext_q;
                frame_rtr_d   = rtr_q;
                frame_dlc_d   = dlc_q;
            end else if (ovr_cnt != '1) begin
                ovr_cnt_d = ovr_cnt + CNT_W'(1);
            end
        end else if (rd_ack) begin
            frame_valid_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_can_rx_sequencer.sv
// Self-checking bench for can_rx_sequencer: drives bit-strobe frames and compares held frames
// through a scoreboard queue, plus error, overrun, idle, lock-loss and reset scenarios.
module tb_can_rx_sequencer;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic       ext;
        logic       rtr;
        logic [3:0] dlc;
    } frm_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             baud_lock, raw_stb, dat_stb, bit_in, stuff_err, crc_zero, rd_ack;
    logic             unstuff_en, crc_clr, cap_en, frame_valid, frame_ext, frame_rtr, bus_idle;
    logic [3:0]       frame_dlc;
    logic [CNT_W-1:0] err_cnt, ovr_cnt;

    int   total = 0;
    int   bad   = 0;
    logic fb[$];
    logic fd[$];
    frm_t sb_q[$];
    frm_t held;
    logic exp_fv  = 1'b0;
    int   exp_ovr = 0;
    int   exp_err = 0;

    always #5 clk = ~clk;

    can_rx_sequencer #(.IDLE_BITS(11), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .baud_lock(baud_lock), .raw_stb(raw_stb), .dat_stb(dat_stb),
        .bit_in(bit_in), .stuff_err(stuff_err), .crc_zero(crc_zero), .rd_ack(rd_ack),
        .unstuff_en(unstuff_en), .crc_clr(crc_clr), .cap_en(cap_en), .frame_valid(frame_valid),
        .frame_ext(frame_ext), .frame_rtr(frame_rtr), .frame_dlc(frame_dlc),
        .err_cnt(err_cnt), .ovr_cnt(ovr_cnt), .bus_idle(bus_idle)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic b, input logic d);
        fb.push_back(b);
        fd.push_back(d);
    endtask

    // Bit-level frame image; one raw-only stuff bit sits inside the identifier
    task automatic build(input frm_t f, input logic [28:0] id, input logic [63:0] data);
        logic [14:0] crc_pat;
        int          nb;
        crc_pat = 15'h2AB3;
        fb.delete();
        fd.delete();
        put(1'b0, 1'b1);
        if (!f.ext) begin
            for (int k = 10; k >= 0; k--) put(id[k], 1'b1);
            put(f.rtr, 1'b1); put(1'b0, 1'b1); put(1'b0, 1'b1);
        end else begin
            for (int k = 28; k >= 18; k--) put(id[k], 1'b1);
            put(1'b1, 1'b1); put(1'b1, 1'b1);
            for (int k = 17; k >= 0; k--) put(id[k], 1'b1);
            put(f.rtr, 1'b1); put(1'b0, 1'b1); put(1'b0, 1'b1);
        end
        for (int k = 3; k >= 0; k--) put(f.dlc[k], 1'b1);
        if (!f.rtr) begin
            nb = (f.dlc > 4'd8) ? 64 : 8 * int'(f.dlc);
            for (int k = 0; k < nb; k++) put(data[63-k], 1'b1);
        end
        for (int k = 14; k >= 0; k--) put(crc_pat[k], 1'b1);
        fb.insert(5, !fb[4]);
        fd.insert(5, 1'b0);
        put(1'b1, 1'b0); put(1'b0, 1'b0); put(1'b1, 1'b0);
        repeat (7) put(1'b1, 1'b0);
    endtask

    task automatic drive_bit(input logic b, input logic d, input logic se, input logic ack);
        raw_stb = 1'b1; dat_stb = d; bit_in = b; stuff_err = se; rd_ack = ack;
        @(negedge clk);
        raw_stb = 1'b0; dat_stb = 1'b0; stuff_err = 1'b0; rd_ack = 1'b0; bit_in = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n) begin
            drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        exp_fv = 1'b0;
        chk("fv_after_ack", 32'(frame_valid), 32'(exp_fv));
    endtask

    task automatic send_frame(input frm_t f, input logic [28:0] id, input logic [63:0] data,
                              input logic crc_ok, input int serr_idx, input int dom_idx,
                              input int stop_idx, input logic ack_last, input logic good);
        int   len, crc_last;
        logic b, last;
        build(f, id, data);
        len      = fb.size();
        crc_last = len - 11;
        for (int i = 0; i < len && i < stop_idx; i++) begin
            b    = (i == dom_idx) ? 1'b0 : fb[i];
            last = (i == len - 1);
            if (i == serr_idx) chk("unstuff_pre_serr", 32'(unstuff_en), 32'd1);
            if (good && last) begin
                chk("fv_pre_commit", 32'(frame_valid), 32'(exp_fv));
                if (!exp_fv || ack_last) sb_q.push_back(f);
                else                     exp_ovr++;
                exp_fv = 1'b1;
            end
            drive_bit(b, fd[i], i == serr_idx, last && ack_last);
            if (i == 0) begin
                chk("crc_clr_sof", 32'(crc_clr), 32'd1);
                chk("unstuff_sof", 32'(unstuff_en), 32'd1);
                chk("cap_sof", 32'(cap_en), 32'd1);
                chk("bus_idle_sof", 32'(bus_idle), 32'd0);
            end
            if (i == serr_idx) chk("unstuff_after_serr", 32'(unstuff_en), 32'd0);
            if (i == crc_last) crc_zero = crc_ok;
            if (i == crc_last + 1) crc_zero = 1'b0;
            if (good && last) begin
                if (sb_q.size() != 0) held = sb_q.pop_front();
                chk("fv_commit", 32'(frame_valid), 32'd1);
                chk("frame_ext", 32'(frame_ext), 32'(held.ext));
                chk("frame_rtr", 32'(frame_rtr), 32'(held.rtr));
                chk("frame_dlc", 32'(frame_dlc), 32'(held.dlc));
                chk("ovr_cnt", 32'(ovr_cnt), 32'(exp_ovr));
                chk("unstuff_off", 32'(unstuff_en), 32'd0);
            end
            @(negedge clk);
        end
        crc_zero = 1'b0;
    endtask

    initial begin
        frm_t f;
        rst_n = 1'b0; baud_lock = 1'b1; raw_stb = 1'b0; dat_stb = 1'b0; bit_in = 1'b1;
        stuff_err = 1'b0; crc_zero = 1'b0; rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_unstuff", 32'(unstuff_en), 32'd0);
        chk("rst_bus_idle", 32'(bus_idle), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_ovr", 32'(ovr_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        idle_bits(10);
        chk("idle_10", 32'(bus_idle), 32'd0);
        idle_bits(1);
        chk("idle_11", 32'(bus_idle), 32'd1);

        // Base data frame
        f = '{ext: 1'b0, rtr: 1'b0, dlc: 4'd2};
        send_frame(f, 29'h123, 64'hA55A_0000_0000_0000, 1'b1, -1, -1, 1000, 1'b0, 1'b1);
        chk("bus_idle_frame_end", 32'(bus_idle), 32'd0);
        idle_bits(3);
        chk("idle_after_eof_3", 32'(bus_idle), 32'd0);
        idle_bits(1);
        chk("idle_after_eof_4", 32'(bus_idle), 32'd1);
        pulse_ack();

        // Extended remote frame, DLC 8 with no data phase
        f = '{ext: 1'b1, rtr: 1'b1, dlc: 4'd8};
        send_frame(f, 29'h1ABCDEF0, 64'h0, 1'b1, -1, -1, 1000, 1'b0, 1'b1);
        idle_bits(4);
        pulse_ack();

        // CRC failure stops before the delimiter
        f = '{ext: 1'b0, rtr: 1'b0, dlc: 4'd2};
        build(f, 29'h123, 64'hA55A_0000_0000_0000);
        send_frame(f, 29'h123, 64'hA55A_0000_0000_0000, 1'b0, -1, -1, fb.size() - 10, 1'b0, 1'b0);
        exp_err++;
        chk("crc_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("crc_err_fv", 32'(frame_valid), 32'd0);
        chk("crc_err_unstuff", 32'(unstuff_en), 32'd0);
        idle_bits(10);
        chk("crc_err_idle_10", 32'(bus_idle), 32'd0);
        idle_bits(1);
        chk("crc_err_idle_11", 32'(bus_idle), 32'd1);

        // Overrun, then an ack coincident with the third commit
        f = '{ext: 1'b0, rtr: 1'b0, dlc: 4'd1};
        send_frame(f, 29'h456, 64'h3C00_0000_0000_0000, 1'b1, -1, -1, 1000, 1'b0, 1'b1);
        idle_bits(4);
        f = '{ext: 1'b0, rtr: 1'b0, dlc: 4'd0};
        send_frame(f, 29'h7FF, 64'h0, 1'b1, -1, -1, 1000, 1'b0, 1'b1);
        idle_bits(4);
        f = '{ext: 1'b1, rtr: 1'b0, dlc: 4'd3};
        send_frame(f, 29'h0000ABC, 64'h1122_3300_0000_0000, 1'b1, -1, -1, 1000, 1'b1, 1'b1);
        idle_bits(4);
        chk("ovr_final", 32'(ovr_cnt), 32'd1);

        // Stuffing violation at identifier bit 5
        f = '{ext: 1'b0, rtr: 1'b0, dlc: 4'd2};
        send_frame(f, 29'h123, 64'hA55A_0000_0000_0000, 1'b1, 7, -1, 8, 1'b0, 1'b0);
        exp_err++;
        chk("serr_err_cnt", 32'(err_cnt), 32'(exp_err));
        idle_bits(11);
        chk("serr_idle", 32'(bus_idle), 32'd1);

        // Dominant bit in EOF; held frame must survive
        build(f, 29'h123, 64'hA55A_0000_0000_0000);
        send_frame(f, 29'h123, 64'hA55A_0000_0000_0000, 1'b1, -1, fb.size() - 3, 1000, 1'b0, 1'b0);
        exp_err++;
        chk("eof_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("eof_err_fv", 32'(frame_valid), 32'd1);
        chk("eof_err_dlc", 32'(frame_dlc), 32'(held.dlc));
        idle_bits(11);
        chk("eof_err_idle", 32'(bus_idle), 32'd1);

        // Lock loss mid-frame
        send_frame(f, 29'h123, 64'hA55A_0000_0000_0000, 1'b1, -1, -1, 25, 1'b0, 1'b0);
        chk("lock_mid_unstuff", 32'(unstuff_en), 32'd1);
        baud_lock = 1'b0;
        repeat (2) @(negedge clk);
        chk("lock_unstuff", 32'(unstuff_en), 32'd0);
        chk("lock_cap", 32'(cap_en), 32'd0);
        baud_lock = 1'b1;
        @(negedge clk);
        chk("lock_err_cnt", 32'(err_cnt), 32'(exp_err));
        idle_bits(11);
        chk("lock_idle", 32'(bus_idle), 32'd1);

        // Async reset at data bit 10 with a frame still held
        send_frame(f, 29'h123, 64'hA55A_0000_0000_0000, 1'b1, -1, -1, 31, 1'b0, 1'b0);
        chk("rst_mid_cap", 32'(cap_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_fv", 32'(frame_valid), 32'd0);
        chk("rstmid_ext", 32'(frame_ext), 32'd0);
        chk("rstmid_dlc", 32'(frame_dlc), 32'd0);
        chk("rstmid_err", 32'(err_cnt), 32'd0);
        chk("rstmid_ovr", 32'(ovr_cnt), 32'd0);
        chk("rstmid_unstuff", 32'(unstuff_en), 32'd0);
        chk("rstmid_cap", 32'(cap_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
